sopc_run_ctrl: RTL and testbench

- Synthesizable run controller that replaces the fixed-delay reset and `$finish` sequencing in the SoPC testbenches.
- Holds one or more SoPC core instances in reset for a programmable number of cycles, then releases them.
- Counts run cycles and snoops each core's data-memory write port for a "tohost" exit write.
- Reports done, pass/fail and timeout status, which the bench polls to end simulation; the same block can drive an FPGA status LED.

---
 rtl/sopc_run_ctrl.sv | 171 +++++++++++++++++
 tb/tb_sopc_run_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sopc_run_ctrl.sv
// sopc_run_ctrl: holds SoPC cores in reset, releases them, then watches
// each core's data-memory write port for a tohost exit write. Reports
// done / pass / timeout for a testbench poller or an FPGA status LED.
module sopc_run_ctrl #(
    parameter int                    NUM_CORES       = 1,
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    RST_HOLD_CYCLES = 20,
    parameter int                    MAX_CYCLES      = 100,
    parameter int                    CNT_WIDTH       = 32,
    parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR     = ADDR_WIDTH'(32'h0000_0100)
) (
    input  logic                            clk,
    input  logic                            rst,
    output logic [NUM_CORES-1:0]            core_rst,
    input  logic [NUM_CORES-1:0]            wr_en,
    input  logic [NUM_CORES*ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_CORES*DATA_WIDTH-1:0] wr_data,
    output logic [CNT_WIDTH-1:0]            cycle_cnt,
    output logic [NUM_CORES-1:0]            exited,
    output logic [NUM_CORES*DATA_WIDTH-1:0] exit_code,
    output logic                            done,
    output logic                            pass,
    output logic                            timeout
);

    localparam int HOLD_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(MAX_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

    // Elaboration-time parameter legality checks.
    if (NUM_CORES < 1 || NUM_CORES > 8) begin : g_bad_num_cores
        $error("sopc_run_ctrl: NUM_CORES must be in 1..8");
    end
    if (RST_HOLD_CYCLES < 1) begin : g_bad_hold
        $error("sopc_run_ctrl: RST_HOLD_CYCLES must be >= 1");
    end
    if (MAX_CYCLES < 1) begin : g_bad_max
        $error("sopc_run_ctrl: MAX_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RUN     = 2'd1,
        ST_FINISH  = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    state_t                          state_q,     state_d;
    logic [HOLD_W-1:0]               hold_cnt_q,  hold_cnt_d;
    logic [CNT_WIDTH-1:0]            cycle_cnt_q, cycle_cnt_d;
    logic [NUM_CORES-1:0]            core_rst_q,  core_rst_d;
    logic [NUM_CORES-1:0]            exited_q,    exited_d;
    logic [NUM_CORES*DATA_WIDTH-1:0] exit_code_q, exit_code_d;
    logic                            done_q,      done_d;
    logic                            pass_q,      pass_d;
    logic                            timeout_q,   timeout_d;
    logic [NUM_CORES-1:0]            cap_s;

    // Saturating increment: the run counter sticks at all-ones.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : (v + CNT_WIDTH'(1'b1));
    endfunction

    // True when every captured exit code is zero.
    function automatic logic codes_all_zero(input logic [NUM_CORES*DATA_WIDTH-1:0] c);
        return ~(|c);
    endfunction

    // Per-core first-tohost-write detection.
    always_comb begin
        cap_s = {NUM_CORES{1'b0}};
        for (int i = 0; i < NUM_CORES; i++) begin
            cap_s[i] = wr_en[i] & (wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == TOHOST_ADDR) & ~exited_q[i];
        end
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        core_rst_d  = core_rst_q;
        exited_d    = exited_q;
        exit_code_d = exit_code_q;
        done_d      = done_q;
        pass_d      = pass_q;
        timeout_d   = timeout_q;
        case (state_q)
            ST_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = ST_RUN;
                    core_rst_d = {NUM_CORES{1'b1}};
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1'b1);
                end
            end
            ST_RUN: begin
                exited_d = exited_q | cap_s;
                for (int i = 0; i < NUM_CORES; i++) begin
                    if (cap_s[i]) begin
                        exit_code_d[i*DATA_WIDTH +: DATA_WIDTH] = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
                    end else begin
                        exit_code_d[i*DATA_WIDTH +: DATA_WIDTH] = exit_code_q[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                if (&exited_d) begin
                    // Last exit wins over a simultaneous limit hit.
                    state_d     = ST_FINISH;
                    done_d      = 1'b1;
                    pass_d      = codes_all_zero(exit_code_d);
                    cycle_cnt_d = sat_inc(cycle_cnt_q);
                end else if (cycle_cnt_q == CNT_LAST) begin
                    // Count is held so it reads the limit index when done rises.
                    state_d    = ST_TIMEOUT;
                    done_d     = 1'b1;
                    timeout_d  = 1'b1;
                    pass_d     = 1'b0;
                    core_rst_d = {NUM_CORES{1'b0}};
                end else begin
                    cycle_cnt_d = sat_inc(cycle_cnt_q);
                end
            end
            ST_FINISH: begin
                state_d = ST_FINISH;
            end
            ST_TIMEOUT: begin
                state_d = ST_TIMEOUT;
            end
            default: begin
                state_d    = ST_HOLD;
                core_rst_d = {NUM_CORES{1'b0}};
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_HOLD;
            hold_cnt_q  <= {HOLD_W{1'b0}};
            cycle_cnt_q <= {CNT_WIDTH{1'b0}};
            core_rst_q  <= {NUM_CORES{1'b0}};
            exited_q    <= {NUM_CORES{1'b0}};
            exit_code_q <= {(NUM_CORES*DATA_WIDTH){1'b0}};
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            core_rst_q  <= core_rst_d;
            exited_q    <= exited_d;
            exit_code_q <= exit_code_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
        end
    end

    assign core_rst  = core_rst_q;
    assign cycle_cnt = cycle_cnt_q;
    assign exited    = exited_q;
    assign exit_code = exit_code_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_sopc_run_ctrl.sv
// Testbench for sopc_run_ctrl: directed vector table, random scenarios
// checked against an outcome model, and an asynchronous mid-run reset.
module tb_sopc_run_ctrl;

    localparam int NC     = 2;
    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int HOLD   = 20;
    localparam int MAXC   = 100;
    localparam int CW     = 32;
    localparam logic [31:0] TOHOST = 32'h0000_0100;
    localparam int NW     = 6;
    localparam int NV     = 6;
    localparam int NRAND  = 30;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NC-1:0]     core_rst;
    logic [NC-1:0]     wr_en = '0;
    logic [NC*AW-1:0]  wr_addr = '0;
    logic [NC*DW-1:0]  wr_data = '0;
    logic [CW-1:0]     cycle_cnt;
    logic [NC-1:0]     exited;
    logic [NC*DW-1:0]  exit_code;
    logic              done, pass, timeout;

    int n_checks = 0;
    int n_errors = 0;

    sopc_run_ctrl #(
        .NUM_CORES(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .RST_HOLD_CYCLES(HOLD), .MAX_CYCLES(MAXC), .CNT_WIDTH(CW),
        .TOHOST_ADDR(TOHOST)
    ) dut (
        .clk(clk), .rst(rst), .core_rst(core_rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cycle_cnt(cycle_cnt), .exited(exited), .exit_code(exit_code),
        .done(done), .pass(pass), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          valid;
        int          cyc;
        int          core;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int          cnt;
        bit          pass;
        bit          timeout;
        logic [1:0]  exited;
        logic [31:0] code0;
        logic [31:0] code1;
    } exp_t;

    typedef struct {
        wr_t  w0, w1, w2, w3;
        exp_t e;
    } vec_t;

    vec_t  vecs[NV];
    string vec_name[NV];
    wr_t   cur_w[NW];

    function automatic wr_t mk_w(input bit v, input int cyc, input int core,
                                 input logic [31:0] addr, input logic [31:0] data);
        wr_t w;
        w.valid = v; w.cyc = cyc; w.core = core; w.addr = addr; w.data = data;
        return w;
    endfunction

    function automatic exp_t mk_e(input int cnt, input bit p, input bit t, input logic [1:0] ex,
                                  input logic [31:0] c0, input logic [31:0] c1);
        exp_t e;
        e.cnt = cnt; e.pass = p; e.timeout = t; e.exited = ex; e.code0 = c0; e.code1 = c1;
        return e;
    endfunction

    // Outcome model: first tohost write per core within the run window decides everything.
    function automatic exp_t model();
        int          ft[NC];
        logic [31:0] fd[NC];
        exp_t        e;
        for (int c = 0; c < NC; c++) begin
            ft[c] = -1;
            fd[c] = 32'h0;
        end
        for (int j = 0; j < NW; j++) begin
            if (cur_w[j].valid && cur_w[j].addr == TOHOST && cur_w[j].cyc <= MAXC - 1) begin
                if (ft[cur_w[j].core] < 0 || cur_w[j].cyc < ft[cur_w[j].core]) begin
                    ft[cur_w[j].core] = cur_w[j].cyc;
                    fd[cur_w[j].core] = cur_w[j].data;
                end
            end
        end
        e.exited = {ft[1] >= 0, ft[0] >= 0};
        e.code0  = fd[0];
        e.code1  = fd[1];
        if (ft[0] >= 0 && ft[1] >= 0) begin
            e.timeout = 1'b0;
            e.cnt     = ((ft[0] > ft[1]) ? ft[0] : ft[1]) + 1;
            e.pass    = (fd[0] == 32'h0) && (fd[1] == 32'h0);
        end else begin
            e.timeout = 1'b1;
            e.cnt     = MAXC - 1;
            e.pass    = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        wr_en = '0; wr_addr = '0; wr_data = '0;
    endtask

    // Drive all tohost candidates scheduled for RUN cycle k.
    task automatic drive_cycle(input int k);
        clear_inputs();
        for (int j = 0; j < NW; j++) begin
            if (cur_w[j].valid && cur_w[j].cyc == k) begin
                wr_en[cur_w[j].core] = 1'b1;
                wr_addr[cur_w[j].core*AW +: AW] = cur_w[j].addr;
                wr_data[cur_w[j].core*DW +: DW] = cur_w[j].data;
            end
        end
    endtask

    // Reset, check the reset state, release and check the full hold window.
    task automatic apply_reset(input string name);
        rst = 1'b0;
        clear_inputs();
        @(posedge clk); #2;
        chk({name, ".rst_core_rst"}, 64'(core_rst), 64'h0);
        chk({name, ".rst_cnt"}, 64'(cycle_cnt), 64'h0);
        chk({name, ".rst_exited"}, 64'(exited), 64'h0);
        chk({name, ".rst_status"}, 64'({done, pass, timeout}), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        // tohost writes during hold must be ignored
        wr_en = 2'b11;
        wr_addr = {TOHOST, TOHOST};
        wr_data = {32'h33, 32'h33};
        for (int e = 1; e <= HOLD; e++) begin
            @(posedge clk); #1;
            chk($sformatf("%s.hold_core_rst_e%0d", name, e), 64'(core_rst),
                (e == HOLD) ? 64'h3 : 64'h0);
            chk($sformatf("%s.hold_cnt_e%0d", name, e), 64'(cycle_cnt), 64'h0);
        end
        clear_inputs();
    endtask

    // Step through RUN cycles 0..last, checking the counter each cycle.
    task automatic run_to(input string name, input int last);
        for (int k = 0; k <= last; k++) begin
            drive_cycle(k);
            chk($sformatf("%s.cnt_k%0d", name, k), 64'(cycle_cnt), 64'(k));
            chk($sformatf("%s.notdone_k%0d", name, k), 64'(done), 64'h0);
            @(posedge clk); #1;
        end
        clear_inputs();
    endtask

    task automatic check_final(input string name, input exp_t e);
        chk({name, ".cnt"}, 64'(cycle_cnt), 64'(e.cnt));
        chk({name, ".done"}, 64'(done), 64'h1);
        chk({name, ".pass"}, 64'(pass), 64'(e.pass));
        chk({name, ".timeout"}, 64'(timeout), 64'(e.timeout));
        chk({name, ".exited"}, 64'(exited), 64'(e.exited));
        chk({name, ".code0"}, 64'(exit_code[31:0]), 64'(e.code0));
        chk({name, ".code1"}, 64'(exit_code[63:32]), 64'(e.code1));
        chk({name, ".core_rst"}, 64'(core_rst), e.timeout ? 64'h0 : 64'h3);
    endtask

    task automatic run_scenario(input string name, input exp_t e);
        apply_reset(name);
        run_to(name, e.timeout ? (MAXC - 1) : (e.cnt - 1));
        check_final(name, e);
        // Terminal states ignore further tohost writes and keep everything frozen.
        wr_en = 2'b11;
        wr_addr = {TOHOST, TOHOST};
        wr_data = {32'h77, 32'h77};
        repeat (3) @(posedge clk);
        #1;
        clear_inputs();
        check_final({name, ".frozen"}, e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual time-limit-expired required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        exp_t em;

        // Directed vector table (expected values worked out by hand).
        vec_name[0] = "pass_c0_at37";
        vecs[0].w0 = mk_w(1'b1, 5, 1, TOHOST, 32'h0);
        vecs[0].w1 = mk_w(1'b1, 37, 0, TOHOST, 32'h0);
        vecs[0].w2 = mk_w(1'b0, 0, 0, 32'h0, 32'h0);
        vecs[0].w3 = mk_w(1'b0, 0, 0, 32'h0, 32'h0);
        vecs[0].e  = mk_e(38, 1'b1, 1'b0, 2'b11, 32'h0, 32'h0);

        vec_name[1] = "fail_first_wins";
        vecs[1].w0 = mk_w(1'b1, 3, 0, 32'h104, 32'h9);
        vecs[1].w1 = mk_w(1'b1, 10, 0, TOHOST, 32'h0);
        vecs[1].w2 = mk_w(1'b1, 12, 0, TOHOST, 32'h5);
        vecs[1].w3 = mk_w(1'b1, 15, 1, TOHOST, 32'h3);
        vecs[1].e  = mk_e(16, 1'b0, 1'b0, 2'b11, 32'h0, 32'h3);

        vec_name[2] = "timeout_none";
        vecs[2].w0 = mk_w(1'b0, 0, 0, 32'h0, 32'h0);
        vecs[2].w1 = mk_w(1'b0, 0, 0, 32'h0, 32'h0);
        vecs[2].w2 = mk_w(1'b0, 0, 0, 32'h0, 32'h0);
        vecs[2].w3 = mk_w(1'b0, 0, 0, 32'h0, 32'h0);
        vecs[2].e  = mk_e(99, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0);

        vec_name[3] = "tie_finish_wins";
        vecs[3].w0 = mk_w(1'b1, 20, 0, TOHOST, 32'h7);
        vecs[3].w1 = mk_w(1'b1, 99, 1, TOHOST, 32'h0);
        vecs[3].w2 = mk_w(1'b0, 0, 0, 32'h0, 32'h0);
        vecs[3].w3 = mk_w(1'b0, 0, 0, 32'h0, 32'h0);
        vecs[3].e  = mk_e(100, 1'b0, 1'b0, 2'b11, 32'h7, 32'h0);

        vec_name[4] = "timeout_partial";
        vecs[4].w0 = mk_w(1'b1, 40, 1, TOHOST, 32'h55);
        vecs[4].w1 = mk_w(1'b1, 60, 0, 32'h104, 32'h0);
        vecs[4].w2 = mk_w(1'b0, 0, 0, 32'h0, 32'h0);
        vecs[4].w3 = mk_w(1'b0, 0, 0, 32'h0, 32'h0);
        vecs[4].e  = mk_e(99, 1'b0, 1'b1, 2'b10, 32'h0, 32'h55);

        vec_name[5] = "both_at_cycle0";
        vecs[5].w0 = mk_w(1'b1, 0, 0, TOHOST, 32'h0);
        vecs[5].w1 = mk_w(1'b1, 0, 1, TOHOST, 32'h0);
        vecs[5].w2 = mk_w(1'b0, 0, 0, 32'h0, 32'h0);
        vecs[5].w3 = mk_w(1'b0, 0, 0, 32'h0, 32'h0);
        vecs[5].e  = mk_e(1, 1'b1, 1'b0, 2'b11, 32'h0, 32'h0);

        for (int v = 0; v < NV; v++) begin
            for (int j = 0; j < NW; j++) cur_w[j] = mk_w(1'b0, 0, 0, 32'h0, 32'h0);
            cur_w[0] = vecs[v].w0;
            cur_w[1] = vecs[v].w1;
            cur_w[2] = vecs[v].w2;
            cur_w[3] = vecs[v].w3;
            run_scenario(vec_name[v], vecs[v].e);
        end

        // Randomized scenarios against the outcome model.
        for (int r = 0; r < NRAND; r++) begin
            for (int j = 0; j < NW; j++) begin
                cur_w[j].valid = 1'b1;
                cur_w[j].core  = int'($urandom % 2);
                cur_w[j].cyc   = int'($urandom_range(0, 110));
                if ($urandom % 4 != 0) cur_w[j].addr = TOHOST;
                else if ($urandom % 2 != 0) cur_w[j].addr = 32'h104;
                else cur_w[j].addr = $urandom;
                cur_w[j].data = ($urandom % 2 != 0) ? 32'h0 : 32'($urandom_range(1, 255));
                for (int p = 0; p < j; p++) begin
                    if (cur_w[p].valid && cur_w[p].core == cur_w[j].core && cur_w[p].cyc == cur_w[j].cyc)
                        cur_w[j].valid = 1'b0;
                end
            end
            em = model();
            run_scenario($sformatf("rand%0d", r), em);
        end

        // Asynchronous reset in the middle of a run, then a full re-hold.
        for (int j = 0; j < NW; j++) cur_w[j] = mk_w(1'b0, 0, 0, 32'h0, 32'h0);
        cur_w[0] = mk_w(1'b1, 10, 0, TOHOST, 32'h9);
        apply_reset("midrst");
        run_to("midrst", 49);
        chk("midrst.pre_cnt", 64'(cycle_cnt), 64'd50);
        chk("midrst.pre_exited", 64'(exited), 64'h1);
        chk("midrst.pre_code0", 64'(exit_code[31:0]), 64'h9);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst.async_core_rst", 64'(core_rst), 64'h0);
        chk("midrst.async_cnt", 64'(cycle_cnt), 64'h0);
        chk("midrst.async_exited", 64'(exited), 64'h0);
        chk("midrst.async_code", 64'(exit_code), 64'h0);
        chk("midrst.async_status", 64'({done, pass, timeout}), 64'h0);
        for (int j = 0; j < NW; j++) cur_w[j] = mk_w(1'b0, 0, 0, 32'h0, 32'h0);
        apply_reset("midrst2");
        run_to("midrst2", 2);
        chk("midrst2.cnt3", 64'(cycle_cnt), 64'd3);
        chk("midrst2.exited", 64'(exited), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
